// File: rtl/seg7_pkg.sv
// Shared segment encodings, the BCD blank code and frame FSM states for the
// scanned 7-segment receive path.
package seg7_pkg;

    // Segment vectors are ordered [7:1] = {g, f, e, d, c, b, a}
    localparam logic [7:1] SEG7_0     = 7'b0111111;
    localparam logic [7:1] SEG7_1     = 7'b0000110;
    localparam logic [7:1] SEG7_2     = 7'b1011011;
    localparam logic [7:1] SEG7_3     = 7'b1001111;
    localparam logic [7:1] SEG7_4     = 7'b1100110;
    localparam logic [7:1] SEG7_5     = 7'b1101101;
    localparam logic [7:1] SEG7_6     = 7'b1111101;
    localparam logic [7:1] SEG7_7     = 7'b0000111;
    localparam logic [7:1] SEG7_8     = 7'b1111111;
    localparam logic [7:1] SEG7_9     = 7'b1101111;
    localparam logic [7:1] SEG7_BLANK = 7'b0000000;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        EMIT
    } frame_state_t;

endpackage

// File: rtl/seg7_scan_capture_if.sv
// Scanned display bus plus the recovered digit/frame results.
interface seg7_scan_capture_if #(
    parameter int NUM_DIGITS = 4
);
    logic [NUM_DIGITS-1:0]   digit_sel;
    logic [7:1]              seven;
    logic                    clear;
    logic [4*NUM_DIGITS-1:0] bcd_digits;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic [NUM_DIGITS-1:0]   pattern_err;
    logic [4*NUM_DIGITS-1:0] frame_bcd;
    logic                    frame_strobe;

    modport master (
        output digit_sel, seven, clear,
        input  bcd_digits, digit_valid, pattern_err, frame_bcd, frame_strobe
    );

    modport slave (
        input  digit_sel, seven, clear,
        output bcd_digits, digit_valid, pattern_err, frame_bcd, frame_strobe
    );
endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern to BCD decoder; blank is legal and maps to 4'hF.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [7:1] seven,
    output logic [3:0] bcd,
    output logic       legal
);
    always_comb begin
        legal = 1'b1;
        bcd   = BCD_BLANK;
        case (seven)
            SEG7_0:     bcd = 4'd0;
            SEG7_1:     bcd = 4'd1;
            SEG7_2:     bcd = 4'd2;
            SEG7_3:     bcd = 4'd3;
            SEG7_4:     bcd = 4'd4;
            SEG7_5:     bcd = 4'd5;
            SEG7_6:     bcd = 4'd6;
            SEG7_7:     bcd = 4'd7;
            SEG7_8:     bcd = 4'd8;
            SEG7_9:     bcd = 4'd9;
            SEG7_BLANK: bcd = BCD_BLANK;
            default:    legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/seg7_scan_capture.sv
// Receive side of a multiplexed 7-segment bus: debounces each dwell, stores BCD per digit
// and publishes a frame once all digits are refreshed. SEG7_SCAN_ACTIVE_LOW_EN inverts inputs.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    seg7_scan_capture_if.slave bus
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    logic [NUM_DIGITS-1:0]   sel_in, sel_reg, sel_prev_reg;
    logic [7:1]              seg_in, seg_reg, seg_prev_reg;
    logic [CW-1:0]           cnt_reg, cnt_next;
    logic                    one_hot, changed, capture;
    logic [3:0]              dec_bcd;
    logic                    dec_legal;
    logic [4*NUM_DIGITS-1:0] bcd_reg, bcd_next, frame_bcd_reg;
    logic [NUM_DIGITS-1:0]   valid_reg, valid_next, err_reg, err_next;
    logic [NUM_DIGITS-1:0]   seen_reg, seen_next, seen_mask;
    logic                    frame_strobe_reg, emit;
    frame_state_t            state_reg, state_next;

`ifdef SEG7_SCAN_ACTIVE_LOW_EN
    assign sel_in = ~bus.digit_sel;
    assign seg_in = ~bus.seven;
`else
    assign sel_in = bus.digit_sel;
    assign seg_in = bus.seven;
`endif

    // Counter tracks how long the registered pair has been stable; capture on arrival at max only
    always_comb begin
        one_hot  = ($countones(sel_reg) == 1);
        changed  = (sel_reg != sel_prev_reg) || (seg_reg != seg_prev_reg);
        cnt_next = cnt_reg;
        if (!one_hot)
            cnt_next = '0;
        else if (changed)
            cnt_next = CW'(1);
        else if (cnt_reg != CNT_MAX)
            cnt_next = cnt_reg + CW'(1);
        capture = one_hot && (cnt_next == CNT_MAX) && (changed || (cnt_reg != CNT_MAX));
    end

    seg7_pattern_decode u_decode (
        .seven (seg_reg),
        .bcd   (dec_bcd),
        .legal (dec_legal)
    );

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        logic hit;
        assign hit = capture && sel_reg[gi];
        // Illegal patterns keep the last good BCD value but flag the digit
        assign bcd_next[4*gi +: 4] = bus.clear ? 4'h0 :
                                     (hit && dec_legal) ? dec_bcd : bcd_reg[4*gi +: 4];
        assign valid_next[gi] = bus.clear ? 1'b0 : (hit ? dec_legal  : valid_reg[gi]);
        assign err_next[gi]   = bus.clear ? 1'b0 : (hit ? ~dec_legal : err_reg[gi]);
    end

    // EMIT starts from an empty mask so a capture in that cycle opens the next frame
    always_comb begin
        state_next = state_reg;
        emit       = 1'b0;
        seen_mask  = ((state_reg == EMIT) ? '0 : seen_reg) | (capture ? sel_reg : '0);
        seen_next  = seen_mask;
        if (bus.clear) begin
            state_next = IDLE;
            seen_next  = '0;
        end else begin
            emit = (state_reg == EMIT);
            if (capture)
                state_next = (&seen_mask) ? EMIT : COLLECT;
            else if (state_reg == EMIT)
                state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_reg          <= '0;
            seg_reg          <= '0;
            sel_prev_reg     <= '0;
            seg_prev_reg     <= '0;
            cnt_reg          <= '0;
            bcd_reg          <= '0;
            valid_reg        <= '0;
            err_reg          <= '0;
            seen_reg         <= '0;
            state_reg        <= IDLE;
            frame_bcd_reg    <= '0;
            frame_strobe_reg <= 1'b0;
        end else begin
            sel_reg          <= sel_in;
            seg_reg          <= seg_in;
            sel_prev_reg     <= sel_reg;
            seg_prev_reg     <= seg_reg;
            cnt_reg          <= cnt_next;
            bcd_reg          <= bcd_next;
            valid_reg        <= valid_next;
            err_reg          <= err_next;
            seen_reg         <= seen_next;
            state_reg        <= state_next;
            frame_strobe_reg <= emit;
            if (emit)
                frame_bcd_reg <= bcd_next;
        end
    end

    assign bus.bcd_digits   = bcd_reg;
    assign bus.digit_valid  = valid_reg;
    assign bus.pattern_err  = err_reg;
    assign bus.frame_bcd    = frame_bcd_reg;
    assign bus.frame_strobe = frame_strobe_reg;
endmodule

// File: tb/tb_seg7_scan_capture.sv
// Scoreboarded bench for seg7_scan_capture: directed scenarios then random dwells,
// predicted by an event-level reference model.
module tb_seg7_scan_capture;
    localparam int N = 4;
    localparam int S = 3;

    typedef struct { int cyc; logic [39:0] val; } exp_t;
    typedef struct { int cyc; logic [15:0] frm; } frm_t;

    logic clk = 1'b0;
    logic rst_n;
    seg7_scan_capture_if #(.NUM_DIGITS(N)) bus_if();

    seg7_scan_capture #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    exp_t exp_q[$];
    frm_t frm_q[$];

    // Logical (active-high) view of what is being driven this cycle
    logic [3:0] d_sel;
    logic [6:0] d_seg;
    bit         d_clr, d_rst;

    // Reference model state
    int         run, mcyc, pend_idx;
    bit         have_last, pend_cap, pend_emit;
    logic [3:0] last_sel;
    logic [6:0] last_seg, pend_seg;
    logic [3:0] m_bcd [N];
    bit         m_valid [N], m_err [N], m_seen [N];
    logic [15:0] m_frame;
    logic [39:0] prev_exp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] ref_decode(input logic [6:0] s);
        case (s)
            7'b0111111: return {1'b1, 4'd0};
            7'b0000110: return {1'b1, 4'd1};
            7'b1011011: return {1'b1, 4'd2};
            7'b1001111: return {1'b1, 4'd3};
            7'b1100110: return {1'b1, 4'd4};
            7'b1101101: return {1'b1, 4'd5};
            7'b1111101: return {1'b1, 4'd6};
            7'b0000111: return {1'b1, 4'd7};
            7'b1111111: return {1'b1, 4'd8};
            7'b1101111: return {1'b1, 4'd9};
            7'b0000000: return {1'b1, 4'hF};
            default:    return {1'b0, 4'h0};
        endcase
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b0111111;  1: return 7'b0000110;  2: return 7'b1011011;
            3: return 7'b1001111;  4: return 7'b1100110;  5: return 7'b1101101;
            6: return 7'b1111101;  7: return 7'b0000111;  8: return 7'b1111111;
            9: return 7'b1101111;  default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [39:0] model_state();
        logic [15:0] b;
        logic [3:0]  v, e;
        for (int i = 0; i < N; i++) begin
            b[4*i +: 4] = m_bcd[i];
            v[i] = m_valid[i];
            e[i] = m_err[i];
        end
        return {m_frame, e, v, b};
    endfunction

    // One clock edge of the behavioural model, using the inputs driven for that edge
    task automatic model_edge();
        bit         cap_now, emit_now, all;
        int         ci;
        logic [6:0] cseg;
        logic [4:0] dec;
        logic [39:0] cur;
        exp_t       ex;
        frm_t       fr;
        mcyc++;
        if (!d_rst) begin
            for (int i = 0; i < N; i++) begin
                m_bcd[i] = 4'h0; m_valid[i] = 0; m_err[i] = 0; m_seen[i] = 0;
            end
            m_frame = '0; pend_cap = 0; pend_emit = 0; run = 0; have_last = 0;
        end else begin
            cap_now = pend_cap; ci = pend_idx; cseg = pend_seg; emit_now = pend_emit;
            pend_cap = 0; pend_emit = 0;
            if (have_last && d_sel == last_sel && d_seg == last_seg) run++;
            else run = 1;
            last_sel = d_sel; last_seg = d_seg; have_last = 1;
            // A pair held for S sampled edges is captured one edge later
            if (run == S && $countones(d_sel) == 1) begin
                pend_cap = 1;
                pend_seg = d_seg;
                for (int i = 0; i < N; i++) if (d_sel[i]) pend_idx = i;
            end
            if (d_clr) begin
                for (int i = 0; i < N; i++) begin
                    m_bcd[i] = 4'h0; m_valid[i] = 0; m_err[i] = 0; m_seen[i] = 0;
                end
            end else begin
                if (cap_now) begin
                    dec = ref_decode(cseg);
                    if (dec[4]) begin
                        m_bcd[ci] = dec[3:0]; m_valid[ci] = 1; m_err[ci] = 0;
                    end else begin
                        m_valid[ci] = 0; m_err[ci] = 1;
                    end
                end
                if (emit_now) begin
                    for (int i = 0; i < N; i++) begin
                        m_frame[4*i +: 4] = m_bcd[i];
                        m_seen[i] = 0;
                    end
                    fr.cyc = mcyc; fr.frm = m_frame;
                    frm_q.push_back(fr);
                end
                if (cap_now) begin
                    m_seen[ci] = 1;
                    all = 1;
                    for (int i = 0; i < N; i++) all &= m_seen[i];
                    if (all) pend_emit = 1;
                end
            end
        end
        cur = model_state();
        if (cur !== prev_exp) begin
            ex.cyc = mcyc; ex.val = cur;
            exp_q.push_back(ex);
            prev_exp = cur;
        end
    endtask

    task automatic tick(input logic [3:0] s, input logic [6:0] g, input bit c, input bit r);
        d_sel = s; d_seg = g; d_clr = c; d_rst = r;
`ifdef SEG7_SCAN_ACTIVE_LOW_EN
        bus_if.digit_sel = ~s;
        bus_if.seven     = ~g;
`else
        bus_if.digit_sel = s;
        bus_if.seven     = g;
`endif
        bus_if.clear = c;
        rst_n        = r;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic dwell(input logic [3:0] s, input logic [6:0] g, input int len);
        for (int j = 0; j < len; j++) tick(s, g, 0, 1);
    endtask

    // Monitor: every observed output change or strobe consumes one expectation
    int          ecnt = 0;
    logic [39:0] last_obs = '0;
    always @(posedge clk) ecnt <= ecnt + 1;

    always @(negedge clk) begin
        logic [39:0] cur;
        exp_t e;
        frm_t f;
        cur = {bus_if.frame_bcd, bus_if.pattern_err, bus_if.digit_valid, bus_if.bcd_digits};
        if (cur !== last_obs) begin
            if (exp_q.size() == 0) begin
                checks++; fails++;
                $display("FAIL unexpected_change: got %0h expected %0h at edge %0d", cur, last_obs, ecnt);
            end else begin
                e = exp_q.pop_front();
                check("out_edge", 64'(ecnt), 64'(e.cyc));
                check("out_value", 64'(cur), 64'(e.val));
            end
            last_obs = cur;
        end
        if (bus_if.frame_strobe !== 1'b0) begin
            if (frm_q.size() == 0) begin
                checks++; fails++;
                $display("FAIL unexpected_strobe: got %b expected 0 at edge %0d", bus_if.frame_strobe, ecnt);
            end else begin
                f = frm_q.pop_front();
                check("strobe_edge", 64'(ecnt), 64'(f.cyc));
                check("frame_bcd", 64'(bus_if.frame_bcd), 64'(f.frm));
            end
        end
    end

    initial begin
        mcyc = 0; run = 0; have_last = 0; pend_cap = 0; pend_emit = 0; pend_idx = 0;
        pend_seg = '0; last_sel = '0; last_seg = '0; m_frame = '0; prev_exp = '0;
        for (int i = 0; i < N; i++) begin
            m_bcd[i] = 4'h0; m_valid[i] = 0; m_err[i] = 0; m_seen[i] = 0;
        end

        // Reset state
        tick(4'b0000, 7'b0, 0, 0);
        tick(4'b0000, 7'b0, 0, 0);
        check("rst_bcd",    64'(bus_if.bcd_digits),   64'h0);
        check("rst_valid",  64'(bus_if.digit_valid),  64'h0);
        check("rst_err",    64'(bus_if.pattern_err),  64'h0);
        check("rst_frame",  64'(bus_if.frame_bcd),    64'h0);
        check("rst_strobe", 64'(bus_if.frame_strobe), 64'h0);
        tick(4'b0000, 7'b0, 0, 1);

        // Basic decode with exact latency
        dwell(4'b0001, 7'b1011011, 3);
        check("t1_before", 64'(bus_if.digit_valid), 64'h0);
        tick(4'b0000, 7'b0, 0, 1);
        check("t1_digit0", 64'(bus_if.bcd_digits[3:0]), 64'd2);
        check("t1_valid",  64'(bus_if.digit_valid),     64'b0001);
        check("t1_strobe", 64'(bus_if.frame_strobe),    64'h0);

        // Glitch rejection
        dwell(4'b0010, 7'b1001111, 2);
        dwell(4'b0010, 7'b1100110, 1);
        dwell(4'b0010, 7'b1001111, 3);
        tick(4'b0000, 7'b0, 0, 1);
        check("t2_digit1", 64'(bus_if.bcd_digits[7:4]), 64'd3);

        // Full frame
        dwell(4'b0001, 7'b0000110, 4);
        dwell(4'b0010, 7'b1101111, 4);
        dwell(4'b0100, 7'b0111111, 4);
        dwell(4'b1000, 7'b0000000, 4);
        check("t3_no_early_strobe", 64'(bus_if.frame_strobe), 64'h0);
        tick(4'b0000, 7'b0, 0, 1);
        check("t3_strobe", 64'(bus_if.frame_strobe), 64'h1);
        check("t3_frame",  64'(bus_if.frame_bcd),    64'hF091);
        tick(4'b0000, 7'b0, 0, 1);
        check("t3_strobe_off", 64'(bus_if.frame_strobe), 64'h0);

        // Illegal pattern, then recovery
        dwell(4'b0100, 7'b1010101, 5);
        check("t4_err",   64'(bus_if.pattern_err[2]),    64'h1);
        check("t4_valid", 64'(bus_if.digit_valid[2]),    64'h0);
        check("t4_held",  64'(bus_if.bcd_digits[11:8]),  64'h0);
        dwell(4'b0100, 7'b0000111, 5);
        check("t4_seven",   64'(bus_if.bcd_digits[11:8]), 64'd7);
        check("t4_err_clr", 64'(bus_if.pattern_err[2]),   64'h0);

        // Bad selects
        dwell(4'b0110, 7'b1111111, 10);
        dwell(4'b0000, 7'b1111111, 10);
        check("t5_bcd",   64'(bus_if.bcd_digits),  64'hF791);
        check("t5_valid", 64'(bus_if.digit_valid), 64'b1111);

        // clear mid-frame keeps the last frame
        tick(4'b0000, 7'b0, 1, 1);
        dwell(4'b0001, seg_of(5), 4);
        dwell(4'b0010, seg_of(6), 4);
        dwell(4'b0100, seg_of(8), 4);
        tick(4'b0000, 7'b0, 1, 1);
        dwell(4'b1000, seg_of(2), 4);
        tick(4'b0000, 7'b0, 0, 1);
        tick(4'b0000, 7'b0, 0, 1);
        check("t6_clear_frame", 64'(bus_if.frame_bcd),  64'hF091);
        check("t6_clear_bcd",   64'(bus_if.bcd_digits), 64'h2000);

        // reset mid-frame wipes the frame
        dwell(4'b0001, seg_of(5), 4);
        dwell(4'b0010, seg_of(6), 4);
        dwell(4'b0100, seg_of(8), 4);
        tick(4'b0000, 7'b0, 0, 0);
        tick(4'b0000, 7'b0, 0, 0);
        dwell(4'b1000, seg_of(2), 4);
        tick(4'b0000, 7'b0, 0, 1);
        tick(4'b0000, 7'b0, 0, 1);
        check("t6_rst_frame", 64'(bus_if.frame_bcd),  64'h0);
        check("t6_rst_bcd",   64'(bus_if.bcd_digits), 64'h2000);

        // Random dwells with occasional clear and reset
        for (int k = 0; k < 300; k++) begin
            logic [3:0] s;
            logic [6:0] g;
            int         len;
            if ($urandom_range(0, 59) == 0) begin
                tick(4'b0001, seg_of(3), 0, 0);
                tick(4'b0001, seg_of(3), 0, 0);
                continue;
            end
            if ($urandom_range(0, 9) < 8) s = 4'b0001 << $urandom_range(0, 3);
            else                          s = 4'($urandom);
            if ($urandom_range(0, 9) < 7) g = seg_of($urandom_range(0, 10));
            else                          g = 7'($urandom);
            len = $urandom_range(1, 8);
            for (int j = 0; j < len; j++)
                tick(s, g, (j == 0) && ($urandom_range(0, 19) == 0), 1);
        end

        repeat (4) tick(4'b0000, 7'b0, 0, 1);
        @(negedge clk);
        #1;
        check("exp_q_drained", 64'(exp_q.size()), 64'h0);
        check("frm_q_drained", 64'(frm_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Receive side of the multiplexed 7-segment display interface.
- Monitors a scanned digit bus: a one-hot digit select plus the active-high segment vector seven[7:1], with bit 1 = a … bit 7 = g.
- Filters glitches per dwell, converts each stable segment pattern back to BCD, and stores it per digit.
- Publishes a complete frame once every digit has been refreshed; used by the scoreboard/controller testbenches and readback logic.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; must be ≥ 1.
- STABLE_CYCLES, 3, consecutive identical registered samples required before a capture; must be ≥ 1.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  synchronous active-low reset.
- digit_sel  in  NUM_DIGITS  one-hot digit enable; bit i selects digit i.
- seven  in  7 [7:1]  segment pattern; bit1 = a … bit7 = g; active-high.
- clear  in  1  synchronous clear of stored digits and frame progress.
- bcd_digits  out  4*NUM_DIGITS  per-digit BCD; digit i occupies [4i+3:4i].
- digit_valid  out  NUM_DIGITS  digit i holds a legal capture.
- pattern_err  out  NUM_DIGITS  sticky flag: digit i's last capture was an illegal pattern.
- frame_bcd  out  4*NUM_DIGITS  snapshot of bcd_digits taken at frame completion.
- frame_strobe  out  1  one-cycle pulse when frame_bcd updates.

Behaviour:
- Reset (rst_n = 0 at an edge) clears every output and all internal state:
  - bcd_digits = 0, digit_valid = 0, pattern_err = 0, frame_bcd = 0, frame_strobe = 0.
  - Stability counter = 0, seen mask = 0, FSM = IDLE.
  - Reset mid-dwell or mid-frame discards all partial progress.
- Input stage: digit_sel and seven are registered once (sample register).
- Stability counter:
  - Reset to 1 when the registered pair differs from its previous value; otherwise increments, saturating at STABLE_CYCLES.
  - Capture fires on the single edge where the counter reaches STABLE_CYCLES.
  - At most one capture per dwell; a long dwell does not recapture.
- Latency: a pair first present at edge t and held updates the outputs at edge t+STABLE_CYCLES; the result is visible after that edge.
- Illegal selects: if the registered digit_sel is not exactly one-hot (zero bits or more than one bit set), the counter is held at 0 and no capture occurs.
- Decode table (seven[7:1] → BCD):
  - 0111111→0, 0000110→1, 1011011→2, 1001111→3, 1100110→4, 1101101→5, 1111101→6, 0000111→7, 1111111→8, 1101111→9.
  - 0000000 → 4'hF (blank); counts as legal.
- On a capture for digit i:
  - Legal pattern: bcd_digits[i] = decoded value, digit_valid[i] = 1, pattern_err[i] = 0.
  - Any other pattern: bcd_digits[i] is held, digit_valid[i] = 0, pattern_err[i] = 1.
  - In both cases seen[i] = 1.
- Frame FSM:
  - IDLE → COLLECT on the first capture.
  - COLLECT → EMIT when the seen mask becomes all-ones, including on that same capture.
  - EMIT lasts one cycle: frame_bcd = bcd_digits (including this cycle's capture), frame_strobe = 1, seen cleared; then → IDLE.
  - A capture arriving during EMIT is recorded into the freshly cleared mask and the FSM moves to COLLECT instead of IDLE.
  - Repeat captures of an already-seen digit update bcd_digits but do not advance the frame.
- clear:
  - Same effect as reset on bcd_digits, digit_valid, pattern_err, the seen mask and the FSM.
  - frame_bcd is retained.
  - clear has priority over a simultaneous capture.
- Boundary: NUM_DIGITS = 1 emits a frame on every capture.

Optional Feature:
- Macro: SEG7_SCAN_ACTIVE_LOW_EN.
- Defined: both seven and digit_sel are inverted at the input register, for common-anode displays driven by active-low decoders. All downstream behaviour is unchanged.
- Undefined: inputs are active-high as specified above.

Decomposition:
- Package seg7_pkg holds:
  - Segment constants SEG7_0…SEG7_9 and SEG7_BLANK (7 bits each).
  - BCD_BLANK = 4'hF.
  - Frame FSM state enum {IDLE, COLLECT, EMIT}.
- Sub-module seg7_pattern_decode: combinational; inputs seven[7:1]; outputs bcd[3:0] and legal. It is shared with other readback logic.

Test Plan:
1. Reset and decode:
   - Stimulus: after reset, drive digit_sel = 0001, seven = 1011011 for 3 cycles.
   - Response: bcd_digits[3:0] = 2 and digit_valid = 0001 exactly 3 edges after first presentation; no frame_strobe.
2. Glitch rejection:
   - Stimulus: digit_sel = 0010, seven = 1001111 for 2 cycles, then 1100110 for 1 cycle, then 1001111 for 3 cycles.
   - Response: exactly one capture, digit 1 = 3.
3. Full frame:
   - Stimulus: scan digits 0–3 with patterns 1, 9, 0, blank, 4 cycles each.
   - Response: single-cycle frame_strobe one edge after the digit-3 capture; frame_bcd = {F, 0, 9, 1} (digit3…digit0).
4. Illegal pattern:
   - Stimulus: digit_sel = 0100, seven = 1010101, held.
   - Response: pattern_err[2] = 1, digit_valid[2] = 0, bcd_digits[2] unchanged; a later legal 0000111 gives 7 and clears the error.
5. Bad select:
   - Stimulus: digit_sel = 0110 or 0000 held for 10 cycles.
   - Response: no capture; outputs unchanged.
6. clear and reset mid-frame:
   - Stimulus: capture digits 0–2, pulse clear, then capture digit 3.
   - Response: no frame_strobe and frame_bcd retained.
   - Repeat with rst_n asserted instead of clear: frame_bcd = 0.
